// File: rtl/chess_timer_pkg.sv
// Shared types and player encodings for the chess turn timer.
package chess_timer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN_WHITE = 2'd1,
        RUN_BLACK = 2'd2,
        TIMEOUT   = 2'd3
    } timer_state_t;

    localparam logic PLAYER_WHITE = 1'b0;
    localparam logic PLAYER_BLACK = 1'b1;

endpackage

// File: rtl/toggle_tick_detector.sv
// Turns every level change of the divided second clock into a one-cycle tick.
module toggle_tick_detector (
    input  logic clock,
    input  logic reset,
    input  logic second_clock,
    output logic tick
);

    logic sec_q_r;

    // Remember last cycle's second_clock level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sec_q_r <= 1'b0;
        end else begin
            sec_q_r <= second_clock;
        end
    end

    assign tick = second_clock ^ sec_q_r;

endmodule

// File: rtl/chess_turn_timer.sv
// Dual countdown chess clock: per-player seconds counters, turn switching and timeout flags.
// Optional Fischer increment on each move is enabled by defining CHESS_INCREMENT_EN.
module chess_turn_timer
    import chess_timer_pkg::*;
#(
    parameter int TIME_WIDTH        = 12,
    parameter int START_SECONDS     = 600,
    parameter int INCREMENT_SECONDS = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  second_clock,
    input  logic                  start,
    input  logic                  move_done,
    input  logic                  pause,
    output logic [TIME_WIDTH-1:0] white_seconds,
    output logic [TIME_WIDTH-1:0] black_seconds,
    output logic                  active_player,
    output logic                  running,
    output logic                  white_timeout,
    output logic                  black_timeout
);

    localparam logic [TIME_WIDTH-1:0] START_C = TIME_WIDTH'(START_SECONDS);
    localparam logic [TIME_WIDTH-1:0] ZERO_C  = TIME_WIDTH'(0);
    localparam logic [TIME_WIDTH-1:0] ONE_C   = TIME_WIDTH'(1);

`ifdef CHESS_INCREMENT_EN
    function automatic logic [TIME_WIDTH-1:0] add_increment(input logic [TIME_WIDTH-1:0] value);
        logic [TIME_WIDTH:0] sum;
        sum = {1'b0, value} + (TIME_WIDTH+1)'(INCREMENT_SECONDS);
        if (sum[TIME_WIDTH]) begin
            return {TIME_WIDTH{1'b1}};
        end else begin
            return sum[TIME_WIDTH-1:0];
        end
    endfunction
`else
    function automatic logic [TIME_WIDTH-1:0] add_increment(input logic [TIME_WIDTH-1:0] value);
        return value;
    endfunction

    logic unused_inc_s;
    assign unused_inc_s = ^(32'(INCREMENT_SECONDS));
`endif

    timer_state_t          state_r, state_n_s;
    logic [TIME_WIDTH-1:0] white_r, white_n_s;
    logic [TIME_WIDTH-1:0] black_r, black_n_s;
    logic [TIME_WIDTH-1:0] cur_s, left_s, bumped_s;
    logic                  active_r, active_n_s;
    logic                  running_r;
    logic                  wto_r, wto_n_s;
    logic                  bto_r, bto_n_s;
    logic                  tick_s;

    toggle_tick_detector u_tick (
        .clock        (clock),
        .reset        (reset),
        .second_clock (second_clock),
        .tick         (tick_s)
    );

    // Next-state and counter update for the game clock.
    always_comb begin
        state_n_s  = state_r;
        white_n_s  = white_r;
        black_n_s  = black_r;
        active_n_s = active_r;
        wto_n_s    = wto_r;
        bto_n_s    = bto_r;
        cur_s      = (state_r == RUN_BLACK) ? black_r : white_r;
        // The decrement lands before any same-cycle switch; a zero counter is treated as expired.
        if (tick_s && (cur_s != ZERO_C)) begin
            left_s = cur_s - ONE_C;
        end else begin
            left_s = cur_s;
        end
        bumped_s = add_increment(left_s);

        case (state_r)
            IDLE, TIMEOUT: begin
                if (start) begin
                    state_n_s  = RUN_WHITE;
                    white_n_s  = START_C;
                    black_n_s  = START_C;
                    active_n_s = PLAYER_WHITE;
                    wto_n_s    = 1'b0;
                    bto_n_s    = 1'b0;
                end else begin
                    state_n_s = state_r;
                end
            end
            RUN_WHITE, RUN_BLACK: begin
                if (pause) begin
                    state_n_s = state_r;
                end else if (left_s == ZERO_C) begin
                    state_n_s = TIMEOUT;
                    if (state_r == RUN_BLACK) begin
                        black_n_s = ZERO_C;
                        bto_n_s   = 1'b1;
                    end else begin
                        white_n_s = ZERO_C;
                        wto_n_s   = 1'b1;
                    end
                end else if (move_done) begin
                    if (state_r == RUN_BLACK) begin
                        black_n_s  = bumped_s;
                        state_n_s  = RUN_WHITE;
                        active_n_s = PLAYER_WHITE;
                    end else begin
                        white_n_s  = bumped_s;
                        state_n_s  = RUN_BLACK;
                        active_n_s = PLAYER_BLACK;
                    end
                end else begin
                    if (state_r == RUN_BLACK) begin
                        black_n_s = left_s;
                    end else begin
                        white_n_s = left_s;
                    end
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            white_r   <= START_C;
            black_r   <= START_C;
            active_r  <= PLAYER_WHITE;
            running_r <= 1'b0;
            wto_r     <= 1'b0;
            bto_r     <= 1'b0;
        end else begin
            state_r   <= state_n_s;
            white_r   <= white_n_s;
            black_r   <= black_n_s;
            active_r  <= active_n_s;
            running_r <= (state_n_s == RUN_WHITE) || (state_n_s == RUN_BLACK);
            wto_r     <= wto_n_s;
            bto_r     <= bto_n_s;
        end
    end

    assign white_seconds = white_r;
    assign black_seconds = black_r;
    assign active_player = active_r;
    assign running       = running_r;
    assign white_timeout = wto_r;
    assign black_timeout = bto_r;

endmodule
